// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin payout (10/5/2/1) with paced pulses and per-denomination inventory
module change_dispenser #(
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned GAP_CYC   = 2,
    parameter int unsigned INIT_N10  = 4,
    parameter int unsigned INIT_N5   = 4,
    parameter int unsigned INIT_N2   = 4,
    parameter int unsigned INIT_N1   = 4
) (
    input  logic       raw_clk_i,
    input  logic       m_switch_i,
    input  logic       start_i,
    input  logic [5:0] amount_i,
    input  logic       refill_i,
    output logic       busy_o,
    output logic       coin10_o,
    output logic       coin5_o,
    output logic       coin2_o,
    output logic       coin1_o,
    output logic       done_o,
    output logic       short_o,
    output logic [5:0] remain_o,
    output logic [3:0] inv10_o,
    output logic [3:0] inv5_o,
    output logic [3:0] inv2_o,
    output logic [3:0] inv1_o
);

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_PULSE, S_GAP, S_DONE} state_t;

    localparam logic [3:0] INIT10     = 4'(INIT_N10);
    localparam logic [3:0] INIT5      = 4'(INIT_N5);
    localparam logic [3:0] INIT2      = 4'(INIT_N2);
    localparam logic [3:0] INIT1      = 4'(INIT_N1);
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);
    localparam logic [7:0] GAP_LAST   = 8'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam bit         HAS_GAP    = (GAP_CYC > 0);

    state_t     state_q, state_d;
    logic [5:0] rem_q, rem_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] coin_q, coin_d;
    logic       short_q, short_d;
    logic [5:0] remain_q, remain_d;
    logic [3:0] inv10_q, inv10_d, inv5_q, inv5_d, inv2_q, inv2_d, inv1_q, inv1_d;

    // One-hot pick of the largest coin that fits the remainder and is still stocked
    logic [3:0] pick;
    logic [5:0] pick_val;

    always_comb begin
        pick     = 4'b0000;
        pick_val = 6'd0;
        if (rem_q >= 6'd10 && inv10_q != 4'd0) begin
            pick = 4'b1000; pick_val = 6'd10;
        end else if (rem_q >= 6'd5 && inv5_q != 4'd0) begin
            pick = 4'b0100; pick_val = 6'd5;
        end else if (rem_q >= 6'd2 && inv2_q != 4'd0) begin
            pick = 4'b0010; pick_val = 6'd2;
        end else if (rem_q >= 6'd1 && inv1_q != 4'd0) begin
            pick = 4'b0001; pick_val = 6'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        coin_d   = coin_q;
        short_d  = short_q;
        remain_d = remain_q;
        inv10_d  = inv10_q;
        inv5_d   = inv5_q;
        inv2_d   = inv2_q;
        inv1_d   = inv1_q;
        case (state_q)
            S_IDLE: begin
                if (refill_i) begin
                    inv10_d = INIT10;
                    inv5_d  = INIT5;
                    inv2_d  = INIT2;
                    inv1_d  = INIT1;
                end
                if (start_i) begin
                    rem_d    = amount_i;
                    short_d  = 1'b0;
                    remain_d = 6'd0;
                    state_d  = S_SELECT;
                end
            end
            S_SELECT: begin
                if (pick == 4'b0000) begin
                    short_d  = (rem_q != 6'd0);
                    remain_d = rem_q;
                    state_d  = S_DONE;
                end else begin
                    rem_d   = rem_q - pick_val;
                    coin_d  = pick;
                    cnt_d   = 8'd0;
                    state_d = S_PULSE;
                    if (pick[3]) inv10_d = inv10_q - 4'd1;
                    if (pick[2]) inv5_d  = inv5_q - 4'd1;
                    if (pick[1]) inv2_d  = inv2_q - 4'd1;
                    if (pick[0]) inv1_d  = inv1_q - 4'd1;
                end
            end
            S_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    coin_d  = 4'b0000;
                    cnt_d   = 8'd0;
                    state_d = HAS_GAP ? S_GAP : S_SELECT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_SELECT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge raw_clk_i or negedge m_switch_i) begin
        if (!m_switch_i) begin
            state_q  <= S_IDLE;
            rem_q    <= 6'd0;
            cnt_q    <= 8'd0;
            coin_q   <= 4'b0000;
            short_q  <= 1'b0;
            remain_q <= 6'd0;
            inv10_q  <= INIT10;
            inv5_q   <= INIT5;
            inv2_q   <= INIT2;
            inv1_q   <= INIT1;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            coin_q   <= coin_d;
            short_q  <= short_d;
            remain_q <= remain_d;
            inv10_q  <= inv10_d;
            inv5_q   <= inv5_d;
            inv2_q   <= inv2_d;
            inv1_q   <= inv1_d;
        end
    end

    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign coin10_o = coin_q[3];
    assign coin5_o  = coin_q[2];
    assign coin2_o  = coin_q[1];
    assign coin1_o  = coin_q[0];
    assign short_o  = short_q;
    assign remain_o = remain_q;
    assign inv10_o  = inv10_q;
    assign inv5_o   = inv5_q;
    assign inv2_o   = inv2_q;
    assign inv1_o   = inv1_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed self-checking bench for change_dispenser
module tb_change_dispenser;

    logic       clk;
    logic       m_switch;
    logic       start;
    logic [5:0] amount;
    logic       refill;
    logic       sel;

    logic       d1_busy, d1_c10, d1_c5, d1_c2, d1_c1, d1_done, d1_short;
    logic [5:0] d1_remain;
    logic [3:0] d1_i10, d1_i5, d1_i2, d1_i1;
    logic       d2_busy, d2_c10, d2_c5, d2_c2, d2_c1, d2_done, d2_short;
    logic [5:0] d2_remain;
    logic [3:0] d2_i10, d2_i5, d2_i2, d2_i1;

    logic       start1, start2, refill1, refill2;
    logic       busy, done, shrt;
    logic [3:0] coins;
    logic [5:0] remain;
    logic [3:0] i10, i5, i2, i1;

    assign start1  = start & ~sel;
    assign start2  = start & sel;
    assign refill1 = refill & ~sel;
    assign refill2 = refill & sel;
    assign busy    = sel ? d2_busy : d1_busy;
    assign done    = sel ? d2_done : d1_done;
    assign shrt    = sel ? d2_short : d1_short;
    assign coins   = sel ? {d2_c10, d2_c5, d2_c2, d2_c1} : {d1_c10, d1_c5, d1_c2, d1_c1};
    assign remain  = sel ? d2_remain : d1_remain;
    assign i10     = sel ? d2_i10 : d1_i10;
    assign i5      = sel ? d2_i5 : d1_i5;
    assign i2      = sel ? d2_i2 : d1_i2;
    assign i1      = sel ? d2_i1 : d1_i1;

    change_dispenser u_dut1 (
        .raw_clk_i(clk), .m_switch_i(m_switch), .start_i(start1), .amount_i(amount),
        .refill_i(refill1), .busy_o(d1_busy), .coin10_o(d1_c10), .coin5_o(d1_c5),
        .coin2_o(d1_c2), .coin1_o(d1_c1), .done_o(d1_done), .short_o(d1_short),
        .remain_o(d1_remain), .inv10_o(d1_i10), .inv5_o(d1_i5), .inv2_o(d1_i2),
        .inv1_o(d1_i1)
    );

    change_dispenser #(.INIT_N1(0), .INIT_N5(1)) u_dut2 (
        .raw_clk_i(clk), .m_switch_i(m_switch), .start_i(start2), .amount_i(amount),
        .refill_i(refill2), .busy_o(d2_busy), .coin10_o(d2_c10), .coin5_o(d2_c5),
        .coin2_o(d2_c2), .coin1_o(d2_c1), .done_o(d2_done), .short_o(d2_short),
        .remain_o(d2_remain), .inv10_o(d2_i10), .inv5_o(d2_i5), .inv2_o(d2_i2),
        .inv1_o(d2_i1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_coins, done_cyc, overlaps, done_cnt;
    int coin_den[16];
    int coin_cyc[16];

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int den_of(input logic [3:0] c);
        case (c)
            4'b1000: return 10;
            4'b0100: return 5;
            4'b0010: return 2;
            4'b0001: return 1;
            default: return 99;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a payout and logs coin rises/done relative to the start edge (cycle 1 = first after it)
    task automatic do_payout(input logic [5:0] amt, input logic with_refill, input int inject_cyc);
        logic [3:0] prev;
        int cyc;
        start = 1'b1; amount = amt; refill = with_refill;
        step();
        start = 1'b0; refill = 1'b0;
        n_coins = 0; done_cyc = -1; overlaps = 0; prev = 4'b0000; cyc = 1;
        for (int k = 0; k < 300; k++) begin
            if (cyc == inject_cyc) begin
                start = 1'b1; amount = 6'd5; refill = 1'b1;
            end else begin
                start = 1'b0; refill = 1'b0;
            end
            if ($countones(coins) > 1) overlaps++;
            if (coins != 4'b0000 && prev == 4'b0000 && n_coins < 16) begin
                coin_den[n_coins] = den_of(coins);
                coin_cyc[n_coins] = cyc;
                n_coins++;
            end
            prev = coins;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            step();
            cyc++;
        end
        start = 1'b0; refill = 1'b0;
        if (done_cyc < 0) check_eq("payout_timeout", 0, 1);
        check_eq("coin_overlap", overlaps, 0);
    endtask

    task automatic do_refill();
        refill = 1'b1;
        step();
        refill = 1'b0;
        check_eq("refill_inv10", i10, 4);
        check_eq("refill_inv5", i5, 4);
        check_eq("refill_inv2", i2, 4);
        check_eq("refill_inv1", i1, 4);
    endtask

    initial begin
        m_switch = 1'b0; start = 1'b0; amount = 6'd0; refill = 1'b0; sel = 1'b0;
        step();
        step();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_coins", coins, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_short", shrt, 0);
        check_eq("rst_remain", remain, 0);
        check_eq("rst_inv10", i10, 4);
        check_eq("rst_inv1", i1, 4);
        m_switch = 1'b1;
        step();

        // T2: zero amount
        do_payout(6'd0, 1'b0, -1);
        check_eq("t2_done_cyc", done_cyc, 2);
        check_eq("t2_ncoins", n_coins, 0);
        check_eq("t2_short", shrt, 0);
        check_eq("t2_remain", remain, 0);
        check_eq("t2_inv5", i5, 4);
        step();
        check_eq("t2_idle_busy", busy, 0);

        // T1: 18 = 10+5+2+1
        do_payout(6'd18, 1'b0, -1);
        check_eq("t1_ncoins", n_coins, 4);
        check_eq("t1_den0", coin_den[0], 10);
        check_eq("t1_den1", coin_den[1], 5);
        check_eq("t1_den2", coin_den[2], 2);
        check_eq("t1_den3", coin_den[3], 1);
        check_eq("t1_cyc0", coin_cyc[0], 2);
        check_eq("t1_cyc1", coin_cyc[1], 7);
        check_eq("t1_cyc2", coin_cyc[2], 12);
        check_eq("t1_cyc3", coin_cyc[3], 17);
        check_eq("t1_done_cyc", done_cyc, 22);
        check_eq("t1_busy_done", busy, 1);
        check_eq("t1_short", shrt, 0);
        check_eq("t1_remain", remain, 0);
        check_eq("t1_inv10", i10, 3);
        check_eq("t1_inv5", i5, 3);
        check_eq("t1_inv2", i2, 3);
        check_eq("t1_inv1", i1, 3);
        step();
        check_eq("t1_done_pulse", done, 0);
        check_eq("t1_idle_busy", busy, 0);
        do_refill();

        // T4: 40 = 4x10 with ignored mid-payout start/refill
        do_payout(6'd40, 1'b0, 4);
        check_eq("t4_ncoins", n_coins, 4);
        check_eq("t4_den3", coin_den[3], 10);
        check_eq("t4_done_cyc", done_cyc, 22);
        check_eq("t4_inv10", i10, 0);
        check_eq("t4_inv5", i5, 4);
        check_eq("t4_short", shrt, 0);
        step();

        // T6: start+refill together with tens drained: payout uses refilled tens
        do_payout(6'd40, 1'b1, -1);
        check_eq("t6_ncoins", n_coins, 4);
        check_eq("t6_den0", coin_den[0], 10);
        check_eq("t6_done_cyc", done_cyc, 22);
        check_eq("t6_short", shrt, 0);
        check_eq("t6_remain", remain, 0);
        check_eq("t6_inv10", i10, 0);
        check_eq("t6_inv5", i5, 4);
        step();
        do_refill();

        // T5: reset during first coin10 pulse
        start = 1'b1; amount = 6'd18;
        step();
        start = 1'b0;
        step();
        check_eq("t5_coin_before", coins, 4'b1000);
        check_eq("t5_inv10_before", i10, 3);
        m_switch = 1'b0;
        #1;
        check_eq("t5_coin_abort", coins, 0);
        check_eq("t5_busy_abort", busy, 0);
        check_eq("t5_inv10_abort", i10, 4);
        done_cnt = 0;
        step();
        if (done) done_cnt++;
        m_switch = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (done || busy) done_cnt++;
        end
        check_eq("t5_no_done", done_cnt, 0);
        do_payout(6'd18, 1'b0, -1);
        check_eq("t5_again_ncoins", n_coins, 4);
        check_eq("t5_again_done_cyc", done_cyc, 22);
        check_eq("t5_again_short", shrt, 0);
        step();

        // T3 on second instance (INIT_N1=0, INIT_N5=1)
        sel = 1'b1;
        #1;
        do_payout(6'd3, 1'b0, -1);
        check_eq("t3a_ncoins", n_coins, 1);
        check_eq("t3a_den0", coin_den[0], 2);
        check_eq("t3a_done_cyc", done_cyc, 7);
        check_eq("t3a_short", shrt, 1);
        check_eq("t3a_remain", remain, 1);
        check_eq("t3a_inv2", i2, 3);
        step();
        step();
        check_eq("t3a_short_held", shrt, 1);
        check_eq("t3a_remain_held", remain, 1);
        do_payout(6'd6, 1'b0, -1);
        check_eq("t3b_ncoins", n_coins, 1);
        check_eq("t3b_den0", coin_den[0], 5);
        check_eq("t3b_done_cyc", done_cyc, 7);
        check_eq("t3b_short", shrt, 1);
        check_eq("t3b_remain", remain, 1);
        check_eq("t3b_inv5", i5, 0);
        check_eq("t3b_inv2", i2, 3);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
